// File: rtl/mist_frame_tracker.sv
// -----------------------------------------------------------------------------
// mist_frame_tracker
//   Synchronises raw VGA vertical sync, horizontal sync and the ROM-download
//   flag into clk, counts frames and derives the controls used by the
//   simulation dump controller: frame counter, frame strobe, download-done
//   pulse, dump window flag and a sticky finish request. All outputs are
//   registered.
//
// Optional feature (define MIST_FRAME_LINECNT_EN):
//   per-frame hs line counting with a line-count-changed indication.
//   When undefined, hs is ignored and lines_last / lines_err are tied to 0.
//
// Parameters
//   WAIT_DL     1: count nothing until the first download completes
//   DUMP_START  first frame_cnt value with dump_on=1
//   DUMP_END    first frame_cnt value with dump_on=0 again (0 = never closes)
//   MAX_FRAMES  frame_cnt value that raises finish (0 = never)
//   LINEW       width of the line counter
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   vs           raw vertical sync, frame starts on falling edge
//   hs           raw horizontal sync, line starts on rising edge
//   downloading  ROM download in progress
//   frame_cnt    frames counted since reset or since the last download ended
//   frame_stb    one-cycle pulse per counted frame
//   dl_done      one-cycle pulse when a download ends
//   dump_on      frame_cnt inside [DUMP_START, DUMP_END)
//   finish       sticky, frame_cnt reached MAX_FRAMES
//   lines_last   hs lines in the previous frame
//   lines_err    line count differs from the frame before
// -----------------------------------------------------------------------------
module mist_frame_tracker #(
    parameter int unsigned WAIT_DL    = 0,
    parameter int unsigned DUMP_START = 0,
    parameter int unsigned DUMP_END   = 0,
    parameter int unsigned MAX_FRAMES = 0,
    parameter int unsigned LINEW      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs,
    input  logic             hs,
    input  logic             downloading,
    output logic [31:0]      frame_cnt,
    output logic             frame_stb,
    output logic             dl_done,
    output logic             dump_on,
    output logic             finish,
    output logic [LINEW-1:0] lines_last,
    output logic             lines_err
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam state_t RESET_STATE = (WAIT_DL != 0) ? ST_WAIT : ST_RUN;
    localparam bit     START_ANY   = (DUMP_START == 0);
    localparam bit     END_NEVER   = (DUMP_END == 0);
    localparam bit     MAX_USED    = (MAX_FRAMES != 0);

    state_t state, state_n;

    // [0],[1]: two-flop synchroniser, [2]: edge register
    logic [2:0] vs_sh;
    logic [2:0] dl_sh;
    logic       vs_fall;
    logic       dl_rise;
    logic       dl_fall;

    logic [31:0] frame_cnt_n;
    logic [31:0] cnt_inc;
    logic        frame_stb_n;
    logic        dl_done_n;
    logic        dump_on_n;
    logic        finish_n;
    logic        count_evt;
    logic        cnt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sh <= '0;
            dl_sh <= '0;
        end else begin
            vs_sh <= {vs_sh[1:0], vs};
            dl_sh <= {dl_sh[1:0], downloading};
        end
    end

    assign vs_fall = vs_sh[2] & ~vs_sh[1];
    assign dl_rise = ~dl_sh[2] & dl_sh[1];
    assign dl_fall = dl_sh[2] & ~dl_sh[1];

    // A download start in the same cycle as a vs edge wins: no frame is counted.
    assign cnt_inc   = frame_cnt + 32'd1;
    assign count_evt = (state == ST_RUN) && vs_fall && !dl_rise;
    assign cnt_hit   = count_evt && MAX_USED && (cnt_inc == MAX_FRAMES);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_n = state;
        unique case (state)
            ST_WAIT: if (dl_rise) state_n = ST_LOAD;
            ST_LOAD: if (dl_fall) state_n = ST_RUN;
            ST_RUN: begin
                if (dl_rise)      state_n = ST_LOAD;
                else if (cnt_hit) state_n = ST_DONE;
            end
            ST_DONE: if (dl_rise) state_n = ST_LOAD;
            default: state_n = RESET_STATE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----------------
    always_comb begin
        frame_cnt_n = frame_cnt;
        frame_stb_n = 1'b0;
        dl_done_n   = 1'b0;
        finish_n    = finish;
        unique case (state)
            ST_LOAD: begin
                frame_cnt_n = '0;
                if (dl_fall) begin
                    dl_done_n = 1'b1;
                    finish_n  = 1'b0;
                end
            end
            ST_RUN: begin
                if (count_evt) begin
                    frame_stb_n = 1'b1;
                    frame_cnt_n = cnt_inc;
                    if (cnt_hit) finish_n = 1'b1;
                end
            end
            default: ;
        endcase
        // Uses the current frame_cnt, so dump_on trails the counter by one cycle.
        dump_on_n = ((state == ST_RUN) || (state == ST_DONE)) &&
                    (START_ANY || (frame_cnt >= DUMP_START)) &&
                    (END_NEVER || (frame_cnt < DUMP_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            frame_stb <= 1'b0;
            dl_done   <= 1'b0;
            dump_on   <= 1'b0;
            finish    <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_n;
            frame_stb <= frame_stb_n;
            dl_done   <= dl_done_n;
            dump_on   <= dump_on_n;
            finish    <= finish_n;
        end
    end

`ifdef MIST_FRAME_LINECNT_EN
    logic [2:0]       hs_sh;
    logic             hs_rise;
    logic [LINEW-1:0] line_cnt;
    logic [1:0]       strobes_seen;

    assign hs_rise = ~hs_sh[2] & hs_sh[1];

    // The first strobe closes a partial frame and the second has nothing valid
    // to compare against, so mismatches are flagged from the third strobe on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_sh        <= '0;
            line_cnt     <= '0;
            lines_last   <= '0;
            lines_err    <= 1'b0;
            strobes_seen <= '0;
        end else begin
            hs_sh <= {hs_sh[1:0], hs};
            if (frame_stb_n) begin
                lines_last <= line_cnt;
                line_cnt   <= LINEW'(hs_rise);
                lines_err  <= (strobes_seen == 2'd2) && (line_cnt != lines_last);
                if (strobes_seen != 2'd2) strobes_seen <= strobes_seen + 2'd1;
            end else begin
                lines_err <= 1'b0;
                if (hs_rise && (line_cnt != '1)) line_cnt <= line_cnt + LINEW'(1);
            end
        end
    end
`else
    logic unused_hs;
    assign unused_hs  = hs;
    assign lines_last = '0;
    assign lines_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mist_frame_tracker.sv
module tb_mist_frame_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    logic hs = 1'b0;
    logic downloading = 1'b0;

    // [0]: DUMP window 4..6, [1]: WAIT_DL=1, [2]: MAX_FRAMES=3
    logic [31:0] cnt [3];
    logic        stb [3];
    logic        dld [3];
    logic        dmp [3];
    logic        fin [3];
    logic [9:0]  ll  [3];
    logic        le  [3];

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mist_frame_tracker #(.WAIT_DL(0), .DUMP_START(4), .DUMP_END(6), .MAX_FRAMES(0), .LINEW(10)) u_win (
        .clk(clk), .rst_n(rst_n), .vs(vs), .hs(hs), .downloading(downloading),
        .frame_cnt(cnt[0]), .frame_stb(stb[0]), .dl_done(dld[0]), .dump_on(dmp[0]),
        .finish(fin[0]), .lines_last(ll[0]), .lines_err(le[0]));

    mist_frame_tracker #(.WAIT_DL(1), .DUMP_START(0), .DUMP_END(0), .MAX_FRAMES(0), .LINEW(10)) u_wait (
        .clk(clk), .rst_n(rst_n), .vs(vs), .hs(hs), .downloading(downloading),
        .frame_cnt(cnt[1]), .frame_stb(stb[1]), .dl_done(dld[1]), .dump_on(dmp[1]),
        .finish(fin[1]), .lines_last(ll[1]), .lines_err(le[1]));

    mist_frame_tracker #(.WAIT_DL(0), .DUMP_START(0), .DUMP_END(0), .MAX_FRAMES(3), .LINEW(10)) u_max (
        .clk(clk), .rst_n(rst_n), .vs(vs), .hs(hs), .downloading(downloading),
        .frame_cnt(cnt[2]), .frame_stb(stb[2]), .dl_done(dld[2]), .dump_on(dmp[2]),
        .finish(fin[2]), .lines_last(ll[2]), .lines_err(le[2]));

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int unsigned nlines [4] = '{0, 262, 262, 263};
`ifdef MIST_FRAME_LINECNT_EN
    int unsigned exp_ll [4] = '{0, 262, 262, 263};
    int unsigned exp_le [4] = '{0, 0, 0, 1};
`else
    int unsigned exp_ll [4] = '{0, 0, 0, 0};
    int unsigned exp_le [4] = '{0, 0, 0, 0};
`endif

    initial begin
        // ---------- reset state ----------
        tick(3);
        for (int unsigned i = 0; i < 3; i++) begin
            chk($sformatf("rst_cnt%0d", i), cnt[i], 0);
            chk($sformatf("rst_stb%0d", i), 32'(stb[i]), 0);
            chk($sformatf("rst_dld%0d", i), 32'(dld[i]), 0);
            chk($sformatf("rst_dmp%0d", i), 32'(dmp[i]), 0);
            chk($sformatf("rst_fin%0d", i), 32'(fin[i]), 0);
            chk($sformatf("rst_ll%0d", i), 32'(ll[i]), 0);
            chk($sformatf("rst_le%0d", i), 32'(le[i]), 0);
        end
        rst_n = 1'b1;
        tick(3);
        chk("dump_from_reset_max", 32'(dmp[2]), 1);
        chk("dump_from_reset_win", 32'(dmp[0]), 0);
        chk("dump_wait_state", 32'(dmp[1]), 0);

        // ---------- 8 frames, no download ----------
        for (int unsigned f = 1; f <= 8; f++) begin
            vs = 1'b0;
            tick(2);
            chk($sformatf("f%0d_early_stb", f), 32'(stb[0]), 0);
            tick(1);
            chk($sformatf("f%0d_stb0", f), 32'(stb[0]), 1);
            chk($sformatf("f%0d_cnt0", f), cnt[0], f);
            chk($sformatf("f%0d_dmp_old", f), 32'(dmp[0]), 32'((f - 1 >= 4) && (f - 1 < 6)));
            chk($sformatf("f%0d_stb1", f), 32'(stb[1]), 0);
            chk($sformatf("f%0d_cnt1", f), cnt[1], 0);
            chk($sformatf("f%0d_stb2", f), 32'(stb[2]), 32'(f <= 3));
            chk($sformatf("f%0d_cnt2", f), cnt[2], (f <= 3) ? f : 3);
            chk($sformatf("f%0d_fin2", f), 32'(fin[2]), 32'(f >= 3));
            tick(1);
            chk($sformatf("f%0d_stb_end", f), 32'(stb[0]), 0);
            chk($sformatf("f%0d_dmp_new", f), 32'(dmp[0]), 32'((f >= 4) && (f < 6)));
            vs = 1'b1;
            tick(96);
        end

        // ---------- download: enter LOAD ----------
        downloading = 1'b1;
        tick(12);
        chk("load_cnt0", cnt[0], 0);
        chk("load_cnt2", cnt[2], 0);
        chk("load_fin2_held", 32'(fin[2]), 1);
        chk("load_dmp2", 32'(dmp[2]), 0);
        vs = 1'b0;
        tick(3);
        chk("load_stb0", 32'(stb[0]), 0);
        chk("load_stb1", 32'(stb[1]), 0);
        chk("load_cnt0_held", cnt[0], 0);
        tick(3);
        vs = 1'b1;
        tick(10);

        // ---------- download ends ----------
        downloading = 1'b0;
        tick(2);
        chk("dld_early", 32'(dld[1]), 0);
        tick(1);
        chk("dld0", 32'(dld[0]), 1);
        chk("dld1", 32'(dld[1]), 1);
        chk("dld2", 32'(dld[2]), 1);
        chk("fin2_cleared", 32'(fin[2]), 0);
        tick(1);
        chk("dld1_once", 32'(dld[1]), 0);
        tick(10);
        for (int unsigned f = 1; f <= 2; f++) begin
            vs = 1'b0;
            tick(3);
            chk($sformatf("post_dl_f%0d_stb1", f), 32'(stb[1]), 1);
            chk($sformatf("post_dl_f%0d_cnt1", f), cnt[1], f);
            chk($sformatf("post_dl_f%0d_cnt2", f), cnt[2], f);
            tick(1);
            chk($sformatf("post_dl_f%0d_stb_end", f), 32'(stb[1]), 0);
            vs = 1'b1;
            tick(30);
        end

        // ---------- vs fall with download rise in the same cycle ----------
        vs = 1'b0;
        downloading = 1'b1;
        tick(3);
        chk("sim_rise_stb0", 32'(stb[0]), 0);
        chk("sim_rise_stb2", 32'(stb[2]), 0);
        chk("sim_rise_cnt2", cnt[2], 2);
        tick(2);
        chk("sim_rise_cnt2_clr", cnt[2], 0);
        chk("sim_rise_dmp2", 32'(dmp[2]), 0);
        vs = 1'b1;
        tick(10);

        // ---------- vs fall with download fall in the same cycle ----------
        vs = 1'b0;
        downloading = 1'b0;
        tick(3);
        chk("sim_fall_dld2", 32'(dld[2]), 1);
        chk("sim_fall_stb2", 32'(stb[2]), 0);
        chk("sim_fall_cnt2", cnt[2], 0);
        tick(1);
        chk("sim_fall_dmp2", 32'(dmp[2]), 1);
        vs = 1'b1;
        tick(10);

        vs = 1'b0;
        tick(3);
        chk("pre_rst_cnt2", cnt[2], 1);
        chk("pre_rst_cnt0", cnt[0], 1);
        vs = 1'b1;
        tick(10);

        // ---------- asynchronous reset mid-frame ----------
        vs = 1'b0;
        tick(1);
        chk("pre_rst_dmp2", 32'(dmp[2]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_cnt2", cnt[2], 0);
        chk("async_dmp2", 32'(dmp[2]), 0);
        chk("async_cnt0", cnt[0], 0);
        chk("async_cnt1", cnt[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        vs = 1'b1;
        tick(10);
        chk("lost_frame_cnt0", cnt[0], 0);
        chk("lost_frame_cnt2", cnt[2], 0);

        // ---------- line counting ----------
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned n = 0; n < nlines[k]; n++) begin
                hs = 1'b1;
                tick(2);
                hs = 1'b0;
                tick(2);
            end
            vs = 1'b0;
            tick(3);
            chk($sformatf("lines_f%0d_stb", k), 32'(stb[0]), 1);
            chk($sformatf("lines_f%0d_last", k), 32'(ll[0]), exp_ll[k]);
            chk($sformatf("lines_f%0d_err", k), 32'(le[0]), exp_le[k]);
            tick(1);
            chk($sformatf("lines_f%0d_err_end", k), 32'(le[0]), 0);
            vs = 1'b1;
            tick(5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
